multicycle_add16_ctrl: RTL and testbench
========================================

// Module: multicycle_add16_ctrl
//
// PURPOSE
// Sequences one SLICE-bit ripple-carry adder slice over WIDTH-bit operands, one slice per cycle
// (LSB slice first), to form a full-width add or subtract. Carry is held in a register between cycles.
// Replaces a wide combinational adder where area matters more than latency. Sits between the operand
// registers and the result bus, with a start/busy/done handshake to its requester.
//
// PARAMETERS
// WIDTH   16  operand/result width; must be a multiple of SLICE
// SLICE    4  width of the adder slice used each cycle
// NSLICE  WIDTH/SLICE  localparam; slices per operation (4 by default)
//
// PORTS
// clk       in   1      single clock; all state updates on rising edge
// rst       in   1      synchronous, active-high reset
// start     in   1      request; sampled only in IDLE
// sub       in   1      0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored)
// cin       in   1      carry-in for add mode
// a         in   WIDTH  operand A; sampled with start
// b         in   WIDTH  operand B; sampled with start
// busy      out  1      high in RUN and DONE
// done      out  1      one-cycle pulse; result outputs are valid from this cycle
// sum       out  WIDTH  result; held until the next accepted start
// cout      out  1      carry out of MSB (for sub: 1 = no borrow)
// ovf       out  1      signed overflow = carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
// - Reset (synchronous, active-high): state=IDLE, slice index=0, carry reg=0, operand regs=0,
//   sum=0, cout=0, ovf=0, busy=0, done=0. Reset in any state aborts the operation with no done pulse.
// - FSM: IDLE -> RUN on start. RUN -> DONE after NSLICE slice cycles. DONE -> IDLE unconditionally.
// - Accept: start=1 in IDLE at edge T. At that edge, latch a, b^{WIDTH{sub}}, and carry = sub ? 1 : cin.
//   Clear sum. Set index=0. busy=1 from T.
// - RUN: in the cycle after edge T+k (k=0..NSLICE-1), the slice adds opA[k], opB[k] and the carry reg.
//   At edge T+k+1, its result is written to sum[k*SLICE +: SLICE], carry reg takes the slice cout,
//   and index increments. Bits written in earlier cycles are not changed.
// - Last slice (k=NSLICE-1): at edge T+NSLICE, cout is taken from the slice carry out.
//   ovf = opA[MSB] ^ opB_eff[MSB] ^ sum[MSB] ^ cout, where sum[MSB] is the newly written bit and
//   opB_eff is the latched (possibly inverted) operand. State becomes DONE.
// - DONE: done=1 for exactly one cycle, i.e. the cycle after edge T+NSLICE. busy stays 1 in DONE.
//   Latency from accepted start to done is NSLICE+1 edges. Throughput is one operation per NSLICE+2 cycles.
// - start while busy (RUN or DONE) is ignored, with no queuing. a/b/sub/cin changes during RUN have no effect.
// - sum/cout/ovf are undefined-but-stable during RUN (partial result). They are valid from done until the next accept.
// - Wrap-around: arithmetic is modulo 2^WIDTH. Overflow is reported only via cout/ovf and never saturates.
// - Index counter width is clog2(NSLICE). In DONE/IDLE it is held at 0.
//
// STRUCTURE
// - Shared package/header: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH/SLICE.
// - One sub-module: add_slice (SLICE-bit ripple adder of full-adder cells; ports s, cout, a, b, cin;
//   purely combinational). One instance. Operand slices are selected by index via indexed part-select.
// - Controller top holds FSM, index counter, carry reg, operand regs, result regs.
//
// TESTING
// 1. add 0x1234+0x4321, cin=0 -> done 5 edges after accept; sum=0x5555, cout=0, ovf=0.
// 2. add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//    Also 0x00FF+0x0000, cin=1 -> sum=0x0100.
// 3. sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//    Also sub 0x0003-0x0005 -> sum=0xFFFE, cout=0, ovf=0.
// 4. add 0x7FFF+0x0001 -> sum=0x8000, ovf=1.
//    Pulse start with new operands at cycles 1-4 of RUN -> ignored; result still 0x8000; done pulses exactly once.
// 5. rst=1 during RUN (after 2 slices) -> next cycle all outputs 0, state IDLE, no done.
//    A fresh start then completes correctly (0x0001+0x0001 -> 0x0002).
// 6. Back-to-back: hold start high continuously -> one accept per 6 cycles; done pulses 1 cycle wide;
//    results match a golden model over 1000 random a/b/sub/cin.

Source files
------------

// File: rtl/multicycle_add16_ctrl_pkg.sv
// Shared types and defaults for the multicycle slice adder.
package multicycle_add16_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multicycle_add16_ctrl_if.sv
// Requester-side bus of the multicycle adder.
//
// Handshake: the requester drives start together with a/b/sub/cin; the
// controller accepts on the first rising edge where start=1 while it is
// idle (busy=0). busy stays high from the accept edge until the cycle
// after done. done is a single-cycle pulse, and sum/cout/ovf are valid
// from the done cycle until the next accepted start. start while busy is
// dropped, never queued.
interface multicycle_add16_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/multicycle_add16_ctrl_add_slice.sv
// SLICE-bit ripple-carry adder built from full-adder cells; purely combinational.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic carry;

  // Ripple the carry from bit 0 upward, one full adder per bit.
  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < SLICE; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/multicycle_add16_ctrl.sv
// Multicycle add/subtract: one SLICE-bit slice per cycle, LSB slice first,
// carry held in a register between cycles.
module multicycle_add16_ctrl
  import multicycle_add16_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_add16_ctrl_if.slave       bus,
  output state_t                       dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic [SLICE-1:0]   slice_s;
  logic               slice_c;
  logic               last_slice;
  int                 base;

  assign base       = int'(idx_q) * SLICE;
  assign last_slice = (idx_q == LAST_IDX);

  add_slice #(.SLICE(SLICE)) u_slice (
    .a    (op_a[base +: SLICE]),
    .b    (op_b[base +: SLICE]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, run NSLICE slices, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, per-slice result write, carry chaining and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (bus.start) begin
            op_a    <= bus.a;
            // Subtract is A + ~B + 1: invert B here, force the carry-in below.
            op_b    <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            sum_q   <= '0;
          end
        end
        ST_RUN: begin
          sum_q[base +: SLICE] <= slice_s;
          carry_q              <= slice_c;
          if (last_slice) begin
            idx_q  <= '0;
            cout_q <= slice_c;
            // a^b^s at the MSB recovers the carry into the MSB.
            ovf_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ slice_s[SLICE-1] ^ slice_c;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: idx_q <= '0;
      endcase
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_add16_ctrl.sv
// Directed and back-to-back random checks for multicycle_add16_ctrl.
module tb_multicycle_add16_ctrl;
  import multicycle_add16_ctrl_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_add16_ctrl_if #(.WIDTH(W)) bus ();
  state_t dbg_state;

  multicycle_add16_ctrl #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // scoreboard: {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // independent golden model of the add/sub
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         v;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    v  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {r[W], v, r[W-1:0]};
  endfunction

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.cin   = cin;
  endtask

  // One accepted operation from IDLE; checks latency and result.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, input logic [W-1:0] e_sum,
                       input logic e_cout, input logic e_ovf);
    int n;
    n = 0;
    drive(1'b1, a, b, sub, cin);
    tick();
    n = 1;
    drive(1'b0, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd5);
    check({tag, "_sum"}, 32'(bus.sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(e_ovf));
    tick();
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
    check({tag, "_held"}, 32'(bus.sum), 32'(e_sum));
    tick();
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_done;
    logic [W+1:0] e;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    // reset state
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_sum",   32'(bus.sum),  32'd0);
    check("rst_cout",  32'(bus.cout), 32'd0);
    check("rst_ovf",   32'(bus.ovf),  32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    do_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_cin",    16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // start pulses during RUN are ignored
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    n_done = 0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k * 16'h1111), 16'h0F0F, 1'(k % 2), 1'b1);
      tick();
      if (bus.done) begin
        n_done++;
        check("ign_sum",  32'(bus.sum),  32'h8000);
        check("ign_cout", 32'(bus.cout), 32'd0);
        check("ign_ovf",  32'(bus.ovf),  32'd1);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) n_done++;
    end
    check("ign_done_count", 32'(n_done), 32'd1);

    // reset mid-operation
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy",  32'(bus.busy), 32'd0);
    check("mrst_done",  32'(bus.done), 32'd0);
    check("mrst_sum",   32'(bus.sum),  32'd0);
    check("mrst_cout",  32'(bus.cout), 32'd0);
    check("mrst_ovf",   32'(bus.ovf),  32'd0);
    check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) n_done++;
    end
    check("mrst_no_done", 32'(n_done), 32'd0);
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // back-to-back with start held high: accept every 6 edges
    for (int j = 0; j < 6000; j++) begin
      logic [W-1:0] ra, rb;
      logic rs, rc;
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      drive(1'b1, ra, rb, rs, rc);
      if (j % 6 == 0) exp_q.push_back(model(ra, rb, rs, rc));
      tick();
      check("b2b_done", 32'(bus.done), 32'((j % 6) == 4));
      if ((j % 6) == 4) begin
        if (exp_q.size() == 0) begin
          check("b2b_queue", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("b2b_result", 32'({bus.cout, bus.ovf, bus.sum}), 32'(e));
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (8) tick();
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
